// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush, memory freeze with timeout and ALU forwarding selects.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int XLEN        = 64,
  parameter int RADDR_W     = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [RADDR_W-1:0] ex_rs1,
  input  logic [RADDR_W-1:0] ex_rs2,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_memread,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               mem_regwrite,
  input  logic               mem_req,
  input  logic               mem_ready,
  input  logic               branch_taken,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic               wb_regwrite,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               id_ex_bubble,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               ex_mem_flush,
  output logic               pipe_freeze,
  output logic [1:0]         forward_a,
  output logic [1:0]         forward_b,
  output logic               mem_timeout,
  output logic               mem_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   wait_cnt
);
  localparam int CW = CNT_W > XLEN ? XLEN : CNT_W;
  localparam int WW = $clog2(MEM_TIMEOUT + 2);
  typedef enum logic {S_RUN, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic mem_timeout_q, mem_timeout_d, mem_err_q, mem_err_d;
  logic load_use, tmo_hit, freeze, flush, stall;
  logic [CW-1:0] stall_q, flush_q, wcnt_q;
  // EX/MEM wins over MEM/WB because it holds the younger result
  assign forward_a = (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs1) ? 2'b10 :
                     (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs1) ? 2'b01 : 2'b00;
  assign forward_b = (mem_regwrite && mem_rd != '0 && mem_rd == ex_rs2) ? 2'b10 :
                     (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs2) ? 2'b01 : 2'b00;
  always_comb begin
    load_use = ex_memread && ex_rd != '0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    tmo_hit = MEM_TIMEOUT > 0 && state_q == S_WAIT && wait_q == WW'(MEM_TIMEOUT) &&
              mem_req && !mem_ready;
    freeze = mem_req && !mem_ready && !tmo_hit;
    flush = !freeze && branch_taken;
    stall = !freeze && !branch_taken && load_use;
    state_d = freeze ? S_WAIT : S_RUN;
    wait_d = !freeze ? '0 : (&wait_q) ? wait_q : wait_q + 1'b1;
    mem_timeout_d = tmo_hit;
    mem_err_d = mem_err_q || tmo_hit;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      wait_q <= '0;
      mem_timeout_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      mem_timeout_q <= mem_timeout_d;
      mem_err_q <= mem_err_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_d, flush_d, wcnt_d;
  always_comb begin
    stall_d = (stall && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    flush_d = (flush && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
    wcnt_d = (freeze && !(&wcnt_q)) ? wcnt_q + 1'b1 : wcnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
      wcnt_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      wcnt_q <= wcnt_d;
    end
  end
`else
  assign stall_q = '0;
  assign flush_q = '0;
  assign wcnt_q = '0;
`endif
  assign stall_cnt = CNT_W'(stall_q);
  assign flush_cnt = CNT_W'(flush_q);
  assign wait_cnt = CNT_W'(wcnt_q);
  assign pipe_freeze = freeze;
  assign pc_write = !freeze && !stall;
  assign if_id_write = !freeze && !stall;
  assign id_ex_bubble = stall;
  assign if_id_flush = flush;
  assign id_ex_flush = flush;
  assign ex_mem_flush = flush;
  assign mem_timeout = mem_timeout_q;
  assign mem_err = mem_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus against a cycle-level reference model with a scoreboard.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 5, MT = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b0;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_memread, mem_regwrite, mem_req, mem_ready, branch_taken, wb_regwrite;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze;
  logic [1:0] forward_a, forward_b;
  logic mem_timeout, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  typedef struct packed {
    logic [6:0] ctrl;
    logic [3:0] fwd;
    logic [1:0] mem;
    logic [CW-1:0] sc, fc, wc;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int run_len, sc, fc, wc;
  bit pulse, err, m_frz, m_st, m_fl, m_hit;

  pipeline_hazard_ctrl #(.XLEN(64), .RADDR_W(RW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pipe_freeze(pipe_freeze),
    .forward_a(forward_a), .forward_b(forward_b), .mem_timeout(mem_timeout), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt));

  always #5 clk = ~clk;

  function automatic logic [1:0] fsel(input logic [RW-1:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input bit inc);
    return (inc && v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    run_len = 0; pulse = 0; err = 0; sc = 0; fc = 0; wc = 0;
  endtask

  task automatic predict(output exp_t e);
    bit lu;
    m_hit = MT > 0 && run_len == MT && mem_req && !mem_ready;
    m_frz = mem_req && !mem_ready && !m_hit;
    lu = ex_memread && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    m_fl = !m_frz && branch_taken;
    m_st = !m_frz && !branch_taken && lu;
    e.ctrl = {!m_frz && !m_st, !m_frz && !m_st, m_st, m_fl, m_fl, m_fl, m_frz};
    e.fwd = {fsel(ex_rs1), fsel(ex_rs2)};
    e.mem = {pulse, err};
`ifdef HAZARD_PERF_CNT_EN
    e.sc = CW'(sc); e.fc = CW'(fc); e.wc = CW'(wc);
`else
    e.sc = '0; e.fc = '0; e.wc = '0;
`endif
  endtask

  task automatic advance();
    run_len = m_frz ? run_len + 1 : 0;
    pulse = m_hit;
    err = err | m_hit;
    sc = sat(sc, m_st);
    fc = sat(fc, m_fl);
    wc = sat(wc, m_frz);
  endtask

  task automatic step();
    exp_t e;
    if (!reset) model_reset();
    predict(e);
    q.push_back(e);
    @(posedge clk);
    if (reset) advance();
    #1;
  endtask

  task automatic clear();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_memread, mem_regwrite, mem_req, mem_ready, branch_taken, wb_regwrite} = '0;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
    tests++;
    if (a !== r) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, r);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctrl", 32'({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze}), 32'(e.ctrl));
      chk("forward", 32'({forward_a, forward_b}), 32'(e.fwd));
      chk("mem_tmo_err", 32'({mem_timeout, mem_err}), 32'(e.mem));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      chk("wait_cnt", 32'(wait_cnt), 32'(e.wc));
    end
  end

  initial begin
    clear();
    model_reset();
    @(posedge clk); #1;
    repeat (2) step();
    reset = 1;
    step();
    set_load_use(); step();
    clear(); step();
    mem_rd = 7; wb_rd = 7; ex_rs1 = 7; ex_rs2 = 7; mem_regwrite = 1; wb_regwrite = 1; step();
    mem_regwrite = 0; step();
    mem_rd = 0; wb_rd = 0; mem_regwrite = 1; step();
    clear(); set_load_use(); branch_taken = 1; step();
    clear(); step();
    mem_req = 1; branch_taken = 1; repeat (3) step();
    mem_ready = 1; step();
    clear(); step();
    mem_req = 1; repeat (MT + 1) step();
    clear(); repeat (2) step();
    mem_req = 1; repeat (2) step();
    reset = 0; step();
    reset = 1; clear(); step();
    set_load_use(); repeat (CMAX + 3) step();
    clear(); step();
    for (int i = 0; i < 500; i++) begin
      id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
      ex_rs1 = RW'($urandom_range(0, 3)); ex_rs2 = RW'($urandom_range(0, 3));
      ex_rd = RW'($urandom_range(0, 3)); mem_rd = RW'($urandom_range(0, 3)); wb_rd = RW'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1)); mem_regwrite = 1'($urandom_range(0, 1));
      wb_regwrite = 1'($urandom_range(0, 1));
      mem_req = $urandom_range(0, 2) == 0 || (pipe_freeze && $urandom_range(0, 3) != 0);
      mem_ready = $urandom_range(0, 2) == 0;
      branch_taken = $urandom_range(0, 3) == 0;
      reset = $urandom_range(0, 149) != 0;
      step();
    end
    reset = 1;
    @(negedge clk); #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
